// File: rtl/usb_hub_repeater_core.sv
// Bit-level USB hub repeater: one direction per packet, host broadcast or one arbitrated
// device up to the host, with babble detection and forced end-of-packet.

module usb_hub_repeater_lane (
  input  logic       hi_clock,
  input  logic       reset,
  input  logic       ld_i,
  input  logic [1:0] sym_d_i,
  input  logic       oe_d_i,
  input  logic       flag_set_i,
  input  logic       flag_clr_i,
  output logic       tx_plus_o,
  output logic       tx_minus_o,
  output logic       tx_oe_o,
  output logic       babble_flag_o
);
  logic [1:0] sym_q;
  logic       oe_q;
  logic       flag_q;

  always_ff @(posedge hi_clock) begin
    if (reset) begin
      sym_q  <= 2'b10;
      oe_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      if (ld_i) begin
        sym_q <= sym_d_i;
        oe_q  <= oe_d_i;
      end
      // set wins over a same-cycle clear
      if (flag_set_i)      flag_q <= 1'b1;
      else if (flag_clr_i) flag_q <= 1'b0;
    end
  end

  assign tx_plus_o     = sym_q[1];
  assign tx_minus_o    = sym_q[0];
  assign tx_oe_o       = oe_q;
  assign babble_flag_o = flag_q;
endmodule

module usb_hub_repeater_core #(
  parameter int NUM_USB_DEVICES = 4,
  parameter int BABBLE_LIMIT    = 1200,
  parameter int ROUND_ROBIN     = 0
) (
  input  logic                       hi_clock,
  input  logic                       reset,
  input  logic                       bit_strobe,
  input  logic                       host_rx_plus,
  input  logic                       host_rx_minus,
  output logic                       host_tx_plus,
  output logic                       host_tx_minus,
  output logic                       host_tx_oe,
  input  logic [NUM_USB_DEVICES-1:0] device_rx_plus,
  input  logic [NUM_USB_DEVICES-1:0] device_rx_minus,
  output logic [NUM_USB_DEVICES-1:0] device_tx_plus,
  output logic [NUM_USB_DEVICES-1:0] device_tx_minus,
  output logic [NUM_USB_DEVICES-1:0] device_tx_oe,
  input  logic [NUM_USB_DEVICES-1:0] port_enable,
  input  logic [NUM_USB_DEVICES-1:0] babble_clear,
  output logic [NUM_USB_DEVICES-1:0] babble_flag,
  output logic [1:0]                 repeater_state
);
  localparam int N  = NUM_USB_DEVICES;
  localparam int CW = $clog2(BABBLE_LIMIT + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DOWN = 2'd1, ST_UP = 2'd2, ST_FEOP = 2'd3} state_e;
  typedef struct packed {
    logic [1:0] sym;
    logic       oe;
  } drv_t;

  state_e            state_q, state_d;
  logic [N-1:0]      act_q, act_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [1:0]        prev_q, prev_d;
  logic [1:0]        fe_q, fe_d;
  drv_t              host_q, host_d;

  logic [N-1:0][1:0] dev_sym;
  logic [N-1:0]      dev_k;
  logic [N-1:0]      eligible;
  logic [N-1:0]      req;
  logic [1:0]        host_sym;
  logic [1:0]        win_sym;
  logic              win_vld;
  logic [IW-1:0]     win_idx;
  int                start;
  int                idx;
  logic [1:0]        dev_sym_d;
  logic [N-1:0]      dev_oe_d;
  logic [N-1:0]      flag_set;

  // SE1 is folded into J so all later compares see only J, K or SE0
  assign host_sym = (host_rx_plus & host_rx_minus) ? SYM_J : {host_rx_plus, host_rx_minus};

  always_comb begin
    dev_sym = '0;
    dev_k   = '0;
    for (int i = 0; i < N; i++) begin
      dev_sym[i] = (device_rx_plus[i] & device_rx_minus[i]) ? SYM_J
                                                            : {device_rx_plus[i], device_rx_minus[i]};
      dev_k[i]   = (dev_sym[i] == SYM_K);
    end
  end

  assign eligible = port_enable & ~babble_flag;
  assign req      = eligible & dev_k;
  assign win_sym  = dev_sym[win_q];
  assign cnt_inc  = (cnt_q == CW'(BABBLE_LIMIT)) ? cnt_q : cnt_q + CW'(1);

  // Search starts at 0 (fixed priority) or one past the last winner (round-robin)
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    start   = (ROUND_ROBIN != 0) ? ((int'(ptr_q) + 1) % N) : 0;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    fe_d      = fe_q;
    host_d    = host_q;
    dev_sym_d = SYM_J;
    dev_oe_d  = '0;
    flag_set  = '0;
    if (bit_strobe) begin
      host_d = '{sym: SYM_J, oe: 1'b0};
      case (state_q)
        ST_IDLE: begin
          if (host_sym == SYM_K) begin
            state_d   = ST_DOWN;
            act_d     = eligible;
            dev_sym_d = SYM_K;
            dev_oe_d  = eligible;
            prev_d    = SYM_K;
          end else if (win_vld) begin
            state_d = ST_UP;
            win_d   = win_idx;
            ptr_d   = win_idx;
            cnt_d   = '0;
            prev_d  = SYM_K;
            host_d  = '{sym: SYM_K, oe: 1'b1};
          end
        end
        ST_DOWN: begin
          act_d    = act_q & port_enable;
          dev_oe_d = act_d;
          prev_d   = host_sym;
          if (prev_q == SYM_SE0 && host_sym == SYM_J) begin
            dev_sym_d = SYM_J;
            state_d   = ST_IDLE;
          end else begin
            dev_sym_d = host_sym;
          end
        end
        ST_UP: begin
          cnt_d     = cnt_inc;
          prev_d    = win_sym;
          host_d.oe = 1'b1;
          // on a termination strobe the host keeps its last symbol; FORCE_EOP drives the rest
          if (!port_enable[win_q]) begin
            state_d = ST_FEOP;
            fe_d    = '0;
            host_d  = host_q;
          end else if (prev_q == SYM_SE0 && win_sym == SYM_J) begin
            host_d.sym = SYM_J;
            state_d    = ST_IDLE;
          end else if (cnt_inc == CW'(BABBLE_LIMIT)) begin
            flag_set[win_q] = 1'b1;
            state_d         = ST_FEOP;
            fe_d            = '0;
            host_d          = host_q;
          end else begin
            host_d.sym = win_sym;
          end
        end
        ST_FEOP: begin
          host_d.oe = 1'b1;
          if (fe_q == 2'd2) begin
            host_d.sym = SYM_J;
            state_d    = ST_IDLE;
          end else begin
            host_d.sym = SYM_SE0;
            fe_d       = fe_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hi_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      prev_q  <= SYM_J;
      fe_q    <= '0;
      host_q  <= '{sym: SYM_J, oe: 1'b0};
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      fe_q    <= fe_d;
      host_q  <= host_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    usb_hub_repeater_lane u_lane (
      .hi_clock      (hi_clock),
      .reset         (reset),
      .ld_i          (bit_strobe),
      .sym_d_i       (dev_oe_d[i] ? dev_sym_d : SYM_J),
      .oe_d_i        (dev_oe_d[i]),
      .flag_set_i    (flag_set[i]),
      .flag_clr_i    (babble_clear[i]),
      .tx_plus_o     (device_tx_plus[i]),
      .tx_minus_o    (device_tx_minus[i]),
      .tx_oe_o       (device_tx_oe[i]),
      .babble_flag_o (babble_flag[i])
    );
  end

  assign host_tx_plus   = host_q.sym[1];
  assign host_tx_minus  = host_q.sym[0];
  assign host_tx_oe     = host_q.oe;
  assign repeater_state = state_q;
endmodule

// File: tb/tb_usb_hub_repeater_core.sv
// Directed scoreboard bench: fixed-priority and round-robin repeaters share all stimulus.
module tb_usb_hub_repeater_core;
  localparam logic [1:0] J = 2'b10, K = 2'b01, S0 = 2'b00;
  localparam logic [2:0] HI = 3'b100, HK = 3'b011, HJ = 3'b101, HS = 3'b001;

  logic hi_clock, reset, bit_strobe, host_rx_plus, host_rx_minus;
  logic [3:0] dev_p, dev_m, port_enable, babble_clear;
  logic htp, htm, hoe, rr_htp, rr_htm, rr_hoe;
  logic [3:0] dtp, dtm, doe, flag, rr_dtp, rr_dtm, rr_doe, rr_flag;
  logic [1:0] st, rr_st;

  usb_hub_repeater_core #(.NUM_USB_DEVICES(4), .BABBLE_LIMIT(16), .ROUND_ROBIN(0)) dut (
    .hi_clock(hi_clock), .reset(reset), .bit_strobe(bit_strobe),
    .host_rx_plus(host_rx_plus), .host_rx_minus(host_rx_minus),
    .host_tx_plus(htp), .host_tx_minus(htm), .host_tx_oe(hoe),
    .device_rx_plus(dev_p), .device_rx_minus(dev_m),
    .device_tx_plus(dtp), .device_tx_minus(dtm), .device_tx_oe(doe),
    .port_enable(port_enable), .babble_clear(babble_clear),
    .babble_flag(flag), .repeater_state(st));

  usb_hub_repeater_core #(.NUM_USB_DEVICES(4), .BABBLE_LIMIT(16), .ROUND_ROBIN(1)) dut_rr (
    .hi_clock(hi_clock), .reset(reset), .bit_strobe(bit_strobe),
    .host_rx_plus(host_rx_plus), .host_rx_minus(host_rx_minus),
    .host_tx_plus(rr_htp), .host_tx_minus(rr_htm), .host_tx_oe(rr_hoe),
    .device_rx_plus(dev_p), .device_rx_minus(dev_m),
    .device_tx_plus(rr_dtp), .device_tx_minus(rr_dtm), .device_tx_oe(rr_doe),
    .port_enable(port_enable), .babble_clear(babble_clear),
    .babble_flag(rr_flag), .repeater_state(rr_st));

  typedef struct {
    string      name;
    logic [2:0] host, host_rr;
    logic [3:0] dp, dm, doe, flag;
    logic [1:0] st, st_rr;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  logic [2:0] e_host, e_hrr;
  logic [3:0] e_dp, e_dm, e_doe, e_flag;
  logic [1:0] e_st, e_strr;

  initial begin
    hi_clock = 0;
    forever #5 hi_clock = ~hi_clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1);
  end

  // Monitor: one expectation per strobe or reset edge, sampled on the following falling edge
  always @(posedge hi_clock) begin
    if (bit_strobe || reset) begin
      exp_t e;
      logic [29:0] act, want;
      @(negedge hi_clock);
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_output: got an output event, expected none pending");
      end else begin
        e = q.pop_front();
        act  = {htp, htm, hoe, dtp, dtm, doe, flag, st, rr_st, rr_htp, rr_htm, rr_hoe, rr_flag};
        want = {e.host, e.dp, e.dm, e.doe, e.flag, e.st, e.st_rr, e.host_rr, e.flag};
        if (act !== want)
          $display("FAIL %s: got host=%b dp=%b dm=%b oe=%b flag=%b st=%0d rr_st=%0d rr_host=%b rr_flag=%b; expected host=%b dp=%b dm=%b oe=%b flag=%b st=%0d rr_st=%0d rr_host=%b",
                   e.name, {htp, htm, hoe}, dtp, dtm, doe, flag, st, rr_st, {rr_htp, rr_htm, rr_hoe}, rr_flag,
                   e.host, e.dp, e.dm, e.doe, e.flag, e.st, e.st_rr, e.host_rr);
        else
          n_pass++;
      end
    end
  end

  task automatic push(input string nm);
    exp_t e;
    e.name = nm; e.host = e_host; e.host_rr = e_hrr; e.dp = e_dp; e.dm = e_dm;
    e.doe = e_doe; e.flag = e_flag; e.st = e_st; e.st_rr = e_strr;
    q.push_back(e);
  endtask

  task automatic strobe(input string nm);
    @(negedge hi_clock);
    bit_strobe = 1'b1;
    push(nm);
    @(negedge hi_clock);
    bit_strobe = 1'b0;
    babble_clear = '0;
  endtask

  task automatic rst_pulse(input string nm);
    @(negedge hi_clock);
    reset = 1'b1;
    push(nm);
    @(negedge hi_clock);
    reset = 1'b0;
  endtask

  task automatic hsym(input logic [1:0] s);
    host_rx_plus = s[1]; host_rx_minus = s[0];
  endtask

  task automatic dsym(input int i, input logic [1:0] s);
    dev_p[i] = s[1]; dev_m[i] = s[0];
  endtask

  task automatic exp_idle();
    e_host = HI; e_hrr = HI; e_dp = 4'hF; e_dm = 4'h0; e_doe = 4'h0; e_st = 2'd0; e_strr = 2'd0;
  endtask

  // Downstream: active ports carry the symbol, inactive ports idle at J with oe low
  task automatic exp_down(input logic [1:0] s, input logic [3:0] act, input logic [1:0] s_st);
    e_dp = ~act | (act & {4{s[1]}}); e_dm = act & {4{s[0]}}; e_doe = act;
    e_host = HI; e_hrr = HI; e_st = s_st; e_strr = s_st;
  endtask

  task automatic exp_up(input logic [2:0] h, input logic [1:0] s_st);
    e_dp = 4'hF; e_dm = 4'h0; e_doe = 4'h0;
    e_host = h; e_hrr = h; e_st = s_st; e_strr = s_st;
  endtask

  initial begin
    reset = 0; bit_strobe = 0; host_rx_plus = 1; host_rx_minus = 0;
    dev_p = 4'hF; dev_m = 4'h0; port_enable = 4'hF; babble_clear = 4'h0;
    e_flag = 4'h0;
    exp_idle();
    for (int i = 0; i < 3; i++) rst_pulse($sformatf("reset_%0d", i));

    // Downstream broadcast to ports 0,1,3
    port_enable = 4'b1011;
    hsym(K);  exp_down(K, 4'b1011, 2'd1);  strobe("bc_k1");
    hsym(J);  exp_down(J, 4'b1011, 2'd1);  strobe("bc_j");
    hsym(K);  exp_down(K, 4'b1011, 2'd1);  strobe("bc_k2");
    hsym(S0); exp_down(S0, 4'b1011, 2'd1); strobe("bc_se0a");
    strobe("bc_se0b");
    hsym(J);  exp_down(J, 4'b1011, 2'd0);  strobe("bc_eop_j");
    exp_idle(); strobe("bc_oe_off");
    port_enable = 4'hF;

    // Upstream arbitration A: devices 1,2 together; both repeaters pick 1, rr pointer -> 1
    dsym(1, K); dsym(2, K); exp_up(HK, 2'd2); strobe("arbA_sop");
    dsym(1, J);             exp_up(HJ, 2'd2); strobe("arbA_j");
    dsym(1, S0);            exp_up(HS, 2'd2); strobe("arbA_se0");
    dsym(1, J); dsym(2, J); exp_up(HJ, 2'd0); strobe("arbA_eop");
    exp_idle(); strobe("arbA_idle");

    // Arbitration B: fixed priority forwards device 1, round-robin forwards device 2
    dsym(1, K); dsym(2, K);  exp_up(HK, 2'd2); strobe("arbB_sop");
    dsym(1, S0); dsym(2, J); exp_up(HS, 2'd2); e_hrr = HJ; strobe("arbB_bit2");
    dsym(1, J); dsym(2, S0); exp_up(HJ, 2'd0); e_hrr = HS; e_strr = 2'd2; strobe("arbB_bit3");
    dsym(2, J);              exp_up(HI, 2'd0); e_hrr = HJ; strobe("arbB_bit4");
    exp_idle(); strobe("arbB_idle");

    // Simultaneous host and device 0 SOP: host wins; port 2 disabled mid-packet
    hsym(K); dsym(0, K); exp_down(K, 4'hF, 2'd1); strobe("sim_sop");
    hsym(S0); dsym(0, J); port_enable = 4'b1011; exp_down(S0, 4'b1011, 2'd1); strobe("sim_se0_drop2");
    hsym(J); exp_down(J, 4'b1011, 2'd0); strobe("sim_eop");
    port_enable = 4'hF; exp_idle(); strobe("sim_idle");

    // Babble on device 3 with limit 16
    dsym(3, K); exp_up(HK, 2'd2); strobe("bab_sop");
    for (int b = 2; b <= 16; b++) begin
      dsym(3, (b % 2 == 1) ? K : J);
      exp_up((b % 2 == 1) ? HK : HJ, 2'd2);
      strobe($sformatf("bab_bit%0d", b));
    end
    dsym(3, K); exp_up(HJ, 2'd3); e_flag = 4'b1000; strobe("bab_flag_set");
    dsym(3, J); exp_up(HS, 2'd3); strobe("bab_fe_se0a");
    dsym(3, K); exp_up(HS, 2'd3); strobe("bab_fe_se0b");
    dsym(3, J); exp_up(HJ, 2'd0); strobe("bab_fe_j");
    exp_idle(); strobe("bab_oe_off");
    dsym(3, K); strobe("bab_k_ignored");
    dsym(3, J); babble_clear = 4'b1000; e_flag = 4'h0; strobe("bab_clear");
    dsym(3, K);  exp_up(HK, 2'd2); strobe("bab_resop");
    dsym(3, S0); exp_up(HS, 2'd2); strobe("bab_re_se0");
    dsym(3, J);  exp_up(HJ, 2'd0); strobe("bab_re_eop");
    exp_idle(); strobe("bab_re_idle");

    // Winner disabled mid-UP: forced EOP, no flag
    dsym(0, K); exp_up(HK, 2'd2); strobe("dis_sop");
    dsym(0, J); exp_up(HJ, 2'd2); strobe("dis_j");
    dsym(0, K); port_enable = 4'b1110; exp_up(HJ, 2'd3); strobe("dis_drop");
    dsym(0, J); exp_up(HS, 2'd3); strobe("dis_fe_se0a");
    exp_up(HS, 2'd3); strobe("dis_fe_se0b");
    exp_up(HJ, 2'd0); strobe("dis_fe_j");
    port_enable = 4'hF; exp_idle(); strobe("dis_idle");

    // Reset in the middle of a downstream packet
    hsym(K); exp_down(K, 4'hF, 2'd1); strobe("rst_sop");
    hsym(J); exp_down(J, 4'hF, 2'd1); strobe("rst_j");
    hsym(K); exp_idle(); rst_pulse("rst_mid_down");
    hsym(J); exp_idle(); strobe("rst_after");

    repeat (4) @(negedge hi_clock);
    n_chk++;
    if (q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
